// File: rtl/pipeline_pkg.sv
// Shared pipeline types: datapath width and the branch target buffer entry layout.
// Pure declarations, no timing or flow control of its own.
package pipeline_pkg;

    localparam int DATA_WIDTH  = 64;
    localparam int BTB_ENTRIES = 16;
    localparam int BTB_TAG_W   = 10;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);

    typedef struct packed {
        logic                  valid;
        logic [BTB_TAG_W-1:0]  tag;
        logic [DATA_WIDTH-1:0] target;
        logic [1:0]            ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down next-state function, pure combinational (0 cycles).
// No handshake; the caller decides when the result is committed.
module sat_counter2 (
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB next-PC predictor: 0-cycle lookup, updates visible the cycle after their edge.
// Always accepts one resolve update per cycle; clear drops a concurrent update but not its mispredict count.
module branch_predictor
    import pipeline_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int TAG_W   = BTB_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    output logic [DATA_WIDTH-1:0] pred_pc,
    output logic                  pred_hit,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_mispredict,
    input  logic                  clear,
    output logic [31:0]           mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t btb_q [ENTRIES];
    btb_entry_t btb_d [ENTRIES];
    logic [31:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]     f_idx, u_idx;
    logic [BTB_TAG_W-1:0] f_tag, u_tag;
    btb_entry_t           f_ent, u_ent;
    logic                 u_hit;
    logic [1:0]           u_ctr_nxt;
    logic                 upd_pc_unused;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = BTB_TAG_W'(fetch_pc[IDX_W+TAG_W+1:IDX_W+2]);
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = BTB_TAG_W'(upd_pc[IDX_W+TAG_W+1:IDX_W+2]);
    assign upd_pc_unused = ^{upd_pc[DATA_WIDTH-1:IDX_W+TAG_W+2], upd_pc[1:0]};

    // Lookup reads the registered array directly, so a same-cycle update is not seen.
    assign f_ent    = btb_q[f_idx];
    assign pred_hit = f_ent.valid && (f_ent.tag == f_tag);
    assign pred_pc  = (pred_hit && f_ent.ctr[1]) ? f_ent.target : fetch_pc + DATA_WIDTH'(4);

    assign u_ent = btb_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

    sat_counter2 u_sat_counter2 (
        .ctr_i (u_ent.ctr),
        .inc_i (upd_taken),
        .ctr_o (u_ctr_nxt)
    );

    always_comb begin
        btb_d = btb_q;
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_d[i].valid = 1'b0;
                btb_d[i].ctr   = 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                btb_d[u_idx].ctr = u_ctr_nxt;
                if (upd_taken) btb_d[u_idx].target = upd_target;
            end else if (upd_taken) begin
                btb_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: 2'b10};
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (upd_valid && upd_mispredict && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            end
            cnt_q <= '0;
        end else begin
            btb_q <= btb_d;
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table-driven lookup/update sequence plus
// hand-written clear, counter saturation and asynchronous reset sequences.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [63:0] fetch_pc;
    logic [63:0] pred_pc;
    logic        pred_hit;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_mispredict;
    logic        clear;
    logic [31:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_pc       (fetch_pc),
        .pred_pc        (pred_pc),
        .pred_hit       (pred_hit),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .clear          (clear),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] fpc;
        logic        uv;
        logic [63:0] upc;
        logic        ut;
        logic [63:0] utgt;
        logic        um;
        logic        ehit;
        logic [63:0] epred;
        logic [31:0] ecnt;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_upd();
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;
        upd_mispredict = 1'b0;
        clear          = 1'b0;
    endtask

    initial begin
        // Expected outputs are the pre-edge (same-cycle) lookup; the update commits on the following posedge.
        vecs[0]  = '{64'h8000_0000, 0, 64'h0,         0, 64'h0,         0, 0, 64'h8000_0004, 0};
        vecs[1]  = '{64'h8000_0010, 1, 64'h8000_0010, 1, 64'h8000_0100, 1, 0, 64'h8000_0014, 0};
        vecs[2]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 64'h0,         0, 1, 64'h8000_0100, 1};
        vecs[3]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 64'h0,         0, 1, 64'h8000_0014, 1};
        vecs[4]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 64'h0,         0, 1, 64'h8000_0014, 1};
        vecs[5]  = '{64'h8000_0010, 1, 64'h8000_0010, 1, 64'h8000_0200, 1, 1, 64'h8000_0014, 1};
        vecs[6]  = '{64'h8000_0010, 1, 64'h8000_0010, 1, 64'h8000_0200, 0, 1, 64'h8000_0014, 2};
        vecs[7]  = '{64'h8000_0010, 1, 64'h8000_0010, 1, 64'h8000_0200, 0, 1, 64'h8000_0200, 2};
        vecs[8]  = '{64'h8000_0010, 1, 64'h8000_0010, 0, 64'h8000_0999, 0, 1, 64'h8000_0200, 2};
        vecs[9]  = '{64'h8000_0010, 0, 64'h0,         0, 64'h0,         0, 1, 64'h8000_0200, 2};
        vecs[10] = '{64'h8000_0010, 1, 64'h8000_0050, 1, 64'h8000_0300, 1, 1, 64'h8000_0200, 2};
        vecs[11] = '{64'h8000_0010, 0, 64'h0,         0, 64'h0,         0, 0, 64'h8000_0014, 3};
        vecs[12] = '{64'h8000_0050, 0, 64'h0,         0, 64'h0,         0, 1, 64'h8000_0300, 3};
        vecs[13] = '{64'h8000_0020, 1, 64'h8000_0020, 1, 64'h8000_0400, 0, 0, 64'h8000_0024, 3};
        vecs[14] = '{64'h8000_0020, 0, 64'h0,         0, 64'h0,         0, 1, 64'h8000_0400, 3};
        vecs[15] = '{64'h8000_0030, 1, 64'h8000_0030, 0, 64'h8000_0600, 0, 0, 64'h8000_0034, 3};
        vecs[16] = '{64'h8000_0030, 0, 64'h0,         0, 64'h0,         0, 0, 64'h8000_0034, 3};
        vecs[17] = '{64'h8000_0040, 0, 64'h8000_0040, 1, 64'h8000_0500, 1, 0, 64'h8000_0044, 3};
        vecs[18] = '{64'h8000_0040, 0, 64'h0,         0, 64'h0,         0, 0, 64'h8000_0044, 3};
        vecs[19] = '{64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0,       0, 0, 64'h0,         3};
        vecs[20] = '{64'h0000_0050, 0, 64'h0,         0, 64'h0,         0, 1, 64'h8000_0300, 3};
        vecs[21] = '{64'h8000_0052, 0, 64'h0,         0, 64'h0,         0, 1, 64'h8000_0300, 3};

        rst_n    = 1'b0;
        fetch_pc = 64'h8000_0000;
        idle_upd();
        #2;
        chk("reset hit", {63'd0, pred_hit}, 64'd0);
        chk("reset pred", pred_pc, 64'h8000_0004);
        chk("reset cnt", {32'd0, mispredict_cnt}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            fetch_pc       = vecs[i].fpc;
            upd_valid      = vecs[i].uv;
            upd_pc         = vecs[i].upc;
            upd_taken      = vecs[i].ut;
            upd_target     = vecs[i].utgt;
            upd_mispredict = vecs[i].um;
            clear          = 1'b0;
            #1;
            chk($sformatf("v%0d hit", i), {63'd0, pred_hit}, {63'd0, vecs[i].ehit});
            chk($sformatf("v%0d pred", i), pred_pc, vecs[i].epred);
            chk($sformatf("v%0d cnt", i), {32'd0, mispredict_cnt}, {32'd0, vecs[i].ecnt});
            @(negedge clk);
        end

        // Clear with a concurrent mispredicting allocate: clear wins, count still moves.
        fetch_pc       = 64'h8000_0050;
        clear          = 1'b1;
        upd_valid      = 1'b1;
        upd_pc         = 64'h8000_0060;
        upd_taken      = 1'b1;
        upd_target     = 64'h8000_0700;
        upd_mispredict = 1'b1;
        #1;
        chk("pre-clear hit", {63'd0, pred_hit}, 64'd1);
        @(negedge clk);
        idle_upd();
        #1;
        chk("clear hit 50", {63'd0, pred_hit}, 64'd0);
        chk("clear pred 50", pred_pc, 64'h8000_0054);
        fetch_pc = 64'h8000_0020;
        #1;
        chk("clear hit 20", {63'd0, pred_hit}, 64'd0);
        fetch_pc = 64'h8000_0060;
        #1;
        chk("clear drop upd", {63'd0, pred_hit}, 64'd0);
        chk("clear cnt", {32'd0, mispredict_cnt}, 64'd4);

        // Counter saturation from a preloaded near-max value.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        upd_valid      = 1'b1;
        upd_pc         = 64'h8000_0080;
        upd_mispredict = 1'b1;
        @(negedge clk);
        #1;
        chk("cnt sat 1", {32'd0, mispredict_cnt}, 64'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("cnt sat 3", {32'd0, mispredict_cnt}, 64'hFFFF_FFFF);
        idle_upd();

        // Asynchronous reset mid-cycle, then an update on the first edge after release.
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 64'h8000_0070;
        upd_taken  = 1'b1;
        upd_target = 64'h8000_0800;
        @(negedge clk);
        idle_upd();
        fetch_pc = 64'h8000_0070;
        #1;
        chk("pre-rst hit", {63'd0, pred_hit}, 64'd1);
        chk("pre-rst pred", pred_pc, 64'h8000_0800);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst hit", {63'd0, pred_hit}, 64'd0);
        chk("arst pred", pred_pc, 64'h8000_0074);
        chk("arst cnt", {32'd0, mispredict_cnt}, 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 64'h8000_0070;
        upd_taken  = 1'b1;
        upd_target = 64'h8000_0900;
        @(negedge clk);
        idle_upd();
        #1;
        chk("post-rst hit", {63'd0, pred_hit}, 64'd1);
        chk("post-rst pred", pred_pc, 64'h8000_0900);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side next-PC predictor supplying the predicted PC that the execute-stage flush logic later compares against the resolved next PC. Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. Fetch looks it up combinationally each cycle. It is trained by the resolve stage on every branch or jump outcome, and it counts mispredictions for performance monitoring.

## Interface
- `ENTRIES`, 16: BTB depth; power of two, 2..256.
- `TAG_W`, 10: stored tag bits.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_pc`  in  DATA_WIDTH  PC being fetched this cycle.
- `pred_pc`  out  DATA_WIDTH  predicted next PC (the `pcp` operand of the flush compare).
- `pred_hit`  out  1  lookup matched a valid entry.
- `upd_valid`  in  1  resolve stage presents a control-flow outcome this cycle.
- `upd_pc`  in  DATA_WIDTH  PC of the resolved branch or jump.
- `upd_taken`  in  1  branch or jump was taken.
- `upd_target`  in  DATA_WIDTH  resolved taken target.
- `upd_mispredict`  in  1  the resolve stage's `pcp != pcn` outcome for this instruction.
- `clear`  in  1  synchronous invalidate-all (fence.i, context switch).
- `mispredict_cnt`  out  32  saturating misprediction count.

## Operation
- Index = `pc[IDX_W+1:2]`, where IDX_W = log2(ENTRIES). Tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`. `pc[1:0]` is ignored, because instructions are 4-byte.
- Entry fields: `valid`, `tag[TAG_W]`, `target[DATA_WIDTH]`, `ctr[2]`.
- Lookup, combinational from `fetch_pc`:
  - `pred_hit = valid & tag match`.
  - `pred_pc = (pred_hit & ctr[1]) ? target : fetch_pc + 4`. The add wraps modulo 2^DATA_WIDTH.
- Update, on a clock edge with `upd_valid=1` and `clear=0`:
  - Hit at `upd_pc`: `ctr` increments if `upd_taken` and decrements otherwise, saturating at 3 and at 0. `target` is overwritten only if `upd_taken`.
  - Miss and `upd_taken`: allocate the entry, evicting the previous occupant. Set `valid=1`, tag and target from the update, `ctr=2'b10`.
  - Miss and not taken: no change.
- Counter: `mispredict_cnt` increments when `upd_valid & upd_mispredict`, and holds at 0xFFFF_FFFF. `clear` does not reset it.
- Clear: on the edge, every `valid` goes to 0 and every `ctr` goes to `2'b01`. Targets and tags may keep stale values.

## Timing
- Reset, asynchronous:
  - all `valid=0`, all `ctr=2'b01`, `mispredict_cnt=0`.
  - Consequently `pred_hit=0` and `pred_pc=fetch_pc+4` immediately, with no clock required.
- Lookup latency is 0 cycles. An update becomes visible to lookups on the cycle after its edge.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents. There is no bypass.
- `clear` together with `upd_valid`: clear wins and the update is dropped. `mispredict_cnt` still counts the update if it is a misprediction.
- At most one update per cycle. `upd_*` are sampled only when `upd_valid=1`.
- Reset deasserting mid-stream: the first edge after deassertion may perform an update.

## Structure
- `pipeline_pkg` holds `DATA_WIDTH` (64) and a new `btb_entry_t` struct `{valid, tag, target, ctr}`, parameterised through localparams derived from `ENTRIES`/`TAG_W`.
- Storage is an `ENTRIES`-deep array of `btb_entry_t` in flops, not SRAM, because of the asynchronous read.
- One sub-module, `sat_counter2`: a 2-bit saturating up/down next-state function. It is used by the update path and is reusable by future predictors.

## Test plan
- Reset: `fetch_pc=0x8000_0000` -> `pred_hit=0`, `pred_pc=0x8000_0004`. `mispredict_cnt=0`.
- Allocate: update with `upd_pc=0x8000_0010`, taken, `upd_target=0x8000_0100`. The next cycle, `fetch_pc=0x8000_0010` -> `pred_hit=1`, `pred_pc=0x8000_0100`.
- Saturation:
  - After allocation, two not-taken updates -> `ctr=0`, and `pred_pc=0x8000_0014` with `pred_hit=1`.
  - A third not-taken update leaves `ctr=0`.
  - Three taken updates -> `ctr=3`.
- Alias: with `ENTRIES=16`, an entry at `0x8000_0010` exists, then a taken update at `0x8000_0050` (same index, different tag) evicts it. Lookup of `0x8000_0010` -> `pred_hit=0`.
- Same-cycle: lookup and allocating update of `0x8000_0020` in one cycle -> that cycle `pred_hit=0`, the next cycle `pred_hit=1`.
- Clear and counter:
  - `clear` together with a mispredicting update -> every lookup misses the next cycle, and `mispredict_cnt` increments by 1.
  - Force the count to 0xFFFF_FFFE, then apply 3 mispredicts -> the count holds at 0xFFFF_FFFF.
